// File: rtl/instr_encoder.sv
// RV32I field-bundle encoder: packs fields into instruction words and queues
// them, with their word addresses, for the instruction-memory write port.
module instr_encoder #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = 10
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     load,
    input  logic [ADDR_W-1:0]        base_addr,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [2:0]               fmt,
    input  logic [6:0]               opcode,
    input  logic [4:0]               rd,
    input  logic [4:0]               rs1,
    input  logic [4:0]               rs2,
    input  logic [2:0]               funct3,
    input  logic [6:0]               funct7,
    input  logic [31:0]              imm,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_instr,
    output logic [ADDR_W-1:0]        out_addr,
    output logic                     err,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5
    } fmt_e;

    logic [31:0]       mem_q [DEPTH];
    logic [31:0]       mem_d [DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [LVL_W-1:0]  level_q, level_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              err_q, err_d;

    logic [31:0]       word_c;
    logic              legal_c;
    logic              imm_s12_c;
    logic              imm_s13_c;
    logic              imm_s21_c;
    logic              accept_c;
    logic              pop_c;
    logic              push_c;

    // Sign-extension checks: the upper immediate bits must all match the sign bit.
    assign imm_s12_c = (&imm[31:11]) | ~(|imm[31:11]);
    assign imm_s13_c = (&imm[31:12]) | ~(|imm[31:12]);
    assign imm_s21_c = (&imm[31:20]) | ~(|imm[31:20]);

    // Pack the fields for the requested format and decide whether the immediate fits.
    always_comb begin
        word_c  = 32'd0;
        legal_c = 1'b0;
        case (fmt_e'(fmt))
            FMT_R: begin
                word_c  = {funct7, rs2, rs1, funct3, rd, opcode};
                legal_c = 1'b1;
            end
            FMT_I: begin
                word_c  = {imm[11:0], rs1, funct3, rd, opcode};
                legal_c = imm_s12_c;
            end
            FMT_S: begin
                word_c  = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
                legal_c = imm_s12_c;
            end
            FMT_B: begin
                word_c  = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
                legal_c = imm_s13_c & ~imm[0];
            end
            FMT_U: begin
                word_c  = {imm[31:12], rd, opcode};
                legal_c = ~(|imm[11:0]);
            end
            FMT_J: begin
                word_c  = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
                legal_c = imm_s21_c & ~imm[0];
            end
            default: begin
                word_c  = 32'd0;
                legal_c = 1'b0;
            end
        endcase
    end

    // Ready depends only on registered occupancy and load, never on out_ready.
    assign in_ready = ~load & (level_q < LVL_W'(DEPTH));
    assign accept_c = in_valid & in_ready;
    assign push_c   = accept_c & legal_c;
    assign pop_c    = ~load & (level_q != '0) & out_ready;

    // Next-state for the FIFO, address counter and reject pulse; load wins over everything.
    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        level_d  = level_q;
        addr_d   = addr_q;
        err_d    = 1'b0;
        if (load) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            level_d  = '0;
            addr_d   = base_addr;
        end else begin
            err_d = accept_c & ~legal_c;
            if (push_c) begin
                mem_d[wr_ptr_q] = word_c;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (pop_c) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
                addr_d   = addr_q + ADDR_W'(1);
            end
            level_d = level_q + LVL_W'(push_c) - LVL_W'(pop_c);
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q    <= '{default: '0};
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            level_q  <= '0;
            addr_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            level_q  <= level_d;
            addr_q   <= addr_d;
            err_q    <= err_d;
        end
    end

    assign out_valid = (level_q != '0);
    assign out_instr = out_valid ? mem_q[rd_ptr_q] : 32'd0;
    assign out_addr  = addr_q;
    assign err       = err_q;
    assign level     = level_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder with a queue-based reference model.
module tb_instr_encoder;

    localparam int unsigned DEPTH  = 4;
    localparam int unsigned ADDR_W = 10;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              load = 1'b0;
    logic [ADDR_W-1:0] base_addr = '0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [2:0]        fmt = '0;
    logic [6:0]        opcode = '0;
    logic [4:0]        rd = '0;
    logic [4:0]        rs1 = '0;
    logic [4:0]        rs2 = '0;
    logic [2:0]        funct3 = '0;
    logic [6:0]        funct7 = '0;
    logic [31:0]       imm = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [31:0]       out_instr;
    logic [ADDR_W-1:0] out_addr;
    logic              err;
    logic [$clog2(DEPTH):0] level;

    int total = 0;
    int bad   = 0;

    instr_encoder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst_n(rst_n), .load(load), .base_addr(base_addr),
        .in_valid(in_valid), .in_ready(in_ready), .fmt(fmt), .opcode(opcode),
        .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3), .funct7(funct7), .imm(imm),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_addr(out_addr), .err(err), .level(level)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [31:0] mq[$];
    int unsigned maddr = 0;
    logic        merr  = 1'b0;

    function automatic logic [31:0] fld(input logic [31:0] v, input int lo, input int n);
        return (v >> lo) & ((32'd1 << n) - 32'd1);
    endfunction

    function automatic logic [31:0] model_encode(input logic [2:0] f, input logic [6:0] op,
        input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
        input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] im);
        logic [31:0] base;
        base = (32'(f3) << 12) | 32'(op);
        case (f)
            3'd0: return (32'(f7) << 25) | (32'(s2) << 20) | (32'(s1) << 15) | (32'(d) << 7) | base;
            3'd1: return (fld(im, 0, 12) << 20) | (32'(s1) << 15) | (32'(d) << 7) | base;
            3'd2: return (fld(im, 5, 7) << 25) | (32'(s2) << 20) | (32'(s1) << 15)
                         | (fld(im, 0, 5) << 7) | base;
            3'd3: return (fld(im, 12, 1) << 31) | (fld(im, 5, 6) << 25) | (32'(s2) << 20)
                         | (32'(s1) << 15) | (fld(im, 1, 4) << 8) | (fld(im, 11, 1) << 7) | base;
            3'd4: return (fld(im, 12, 20) << 12) | (32'(d) << 7) | 32'(op);
            default: return (fld(im, 20, 1) << 31) | (fld(im, 1, 10) << 21) | (fld(im, 11, 1) << 20)
                         | (fld(im, 12, 8) << 12) | (32'(d) << 7) | 32'(op);
        endcase
    endfunction

    function automatic bit model_legal(input logic [2:0] f, input logic [31:0] im);
        int s;
        s = $signed(im);
        case (f)
            3'd0: return 1'b1;
            3'd1, 3'd2: return (s >= -2048) && (s <= 2047);
            3'd3: return (s >= -4096) && (s <= 4095) && (s % 2 == 0);
            3'd4: return (im % 4096) == 0;
            3'd5: return (s >= -(1 << 20)) && (s < (1 << 20)) && (s % 2 == 0);
            default: return 1'b0;
        endcase
    endfunction

    function automatic bit model_ready();
        return (mq.size() < DEPTH) && !load;
    endfunction

    // Model advances on the same edges as the design, using pre-edge inputs.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            maddr = 0;
            merr  = 1'b0;
        end else if (load) begin
            mq.delete();
            maddr = base_addr;
            merr  = 1'b0;
        end else begin
            bit acc;
            acc  = in_valid && (mq.size() < DEPTH);
            merr = 1'b0;
            if (mq.size() > 0 && out_ready) begin
                void'(mq.pop_front());
                maddr = (maddr + 1) % (1 << ADDR_W);
            end
            if (acc) begin
                if (model_legal(fmt, imm))
                    mq.push_back(model_encode(fmt, opcode, rd, rs1, rs2, funct3, funct7, imm));
                else
                    merr = 1'b1;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic set_fields(input logic [2:0] f, input logic [6:0] op, input logic [4:0] d,
        input logic [4:0] s1, input logic [4:0] s2, input logic [2:0] f3,
        input logic [6:0] f7, input logic [31:0] im);
        fmt = f; opcode = op; rd = d; rs1 = s1; rs2 = s2; funct3 = f3; funct7 = f7; imm = im;
    endtask

    task automatic push(input logic [2:0] f, input logic [6:0] op, input logic [4:0] d,
        input logic [4:0] s1, input logic [4:0] s2, input logic [2:0] f3,
        input logic [6:0] f7, input logic [31:0] im);
        set_fields(f, op, d, s1, s2, f3, f7, im);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    task automatic do_load(input logic [ADDR_W-1:0] b);
        load = 1'b1;
        base_addr = b;
        step();
        load = 1'b0;
    endtask

    // ---------------- stimulus + per-cycle compare ----------------
    initial begin
        fork
            begin : stim
                #3;
                chk("rst_out_valid", 32'(out_valid), 32'd0);
                chk("rst_level", 32'(level), 32'd0);
                chk("rst_out_instr", out_instr, 32'd0);
                chk("rst_err", 32'(err), 32'd0);
                step(); step();
                rst_n = 1'b1;
                chk("rst_in_ready", 32'(in_ready), 32'd1);

                // R-type, streaming out immediately
                do_load(10'h010);
                chk("load_level", 32'(level), 32'd0);
                out_ready = 1'b1;
                push(3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
                chk("r_instr", out_instr, 32'h002081B3);
                chk("r_addr", 32'(out_addr), 32'h010);
                step();
                chk("r_drained", 32'(level), 32'd0);

                // I then S, held then released
                do_load(10'h010);
                out_ready = 1'b0;
                push(3'd1, 7'h13, 5'd16, 5'd4, 5'd0, 3'd0, 7'd0, 32'd99);
                push(3'd2, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8);
                chk("i_instr", out_instr, 32'h06320813);
                chk("i_addr", 32'(out_addr), 32'h010);
                chk("is_level", 32'(level), 32'd2);
                out_ready = 1'b1;
                step();
                chk("s_instr", out_instr, 32'h0020A423);
                chk("s_addr", 32'(out_addr), 32'h011);
                step();

                // rejected bundles
                push(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd5);
                chk("b_odd_err", 32'(err), 32'd1);
                chk("b_odd_level", 32'(level), 32'd0);
                chk("b_odd_valid", 32'(out_valid), 32'd0);
                step();
                chk("err_pulse_end", 32'(err), 32'd0);
                push(3'd7, 7'h13, 5'd1, 5'd1, 5'd1, 3'd0, 7'd0, 32'd0);
                chk("fmt7_err", 32'(err), 32'd1);
                push(3'd1, 7'h13, 5'd1, 5'd1, 5'd0, 3'd0, 7'd0, 32'd2048);
                chk("i2048_err", 32'(err), 32'd1);
                chk("i2048_level", 32'(level), 32'd0);
                step();

                // legal B, U, J
                out_ready = 1'b0;
                push(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'hFFFF_FFF8);
                chk("b_instr", out_instr, 32'hFE208CE3);
                out_ready = 1'b1;
                step();
                out_ready = 1'b0;
                push(3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000);
                chk("u_instr", out_instr, 32'h123452B7);
                out_ready = 1'b1;
                step();
                out_ready = 1'b0;
                push(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048);
                chk("j_instr", out_instr, 32'h001000EF);
                out_ready = 1'b1;
                step();

                // fill to capacity with the sink stalled
                out_ready = 1'b0;
                for (int i = 0; i < 8; i++)
                    push(3'd1, 7'h13, 5'(i + 1), 5'd0, 5'd0, 3'd0, 7'd0, 32'(i * 3));
                chk("full_level", 32'(level), 32'd4);
                chk("full_ready", 32'(in_ready), 32'd0);
                step(); step();
                chk("full_head", out_instr, 32'h00000093);
                out_ready = 1'b1;
                for (int i = 0; i < 4; i++) step();
                chk("drain_level", 32'(level), 32'd0);

                // load with entries queued, then wrap the address
                out_ready = 1'b0;
                push(3'd1, 7'h13, 5'd9, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1);
                push(3'd1, 7'h13, 5'd10, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2);
                set_fields(3'd0, 7'h33, 5'd1, 5'd1, 5'd1, 3'd0, 7'd0, 32'd0);
                in_valid = 1'b1;
                out_ready = 1'b1;
                do_load(10'h3FF);
                in_valid = 1'b0;
                out_ready = 1'b0;
                chk("flush_level", 32'(level), 32'd0);
                chk("flush_valid", 32'(out_valid), 32'd0);
                chk("flush_addr", 32'(out_addr), 32'h3FF);
                push(3'd1, 7'h13, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd7);
                push(3'd1, 7'h13, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 32'd8);
                chk("wrap_addr0", 32'(out_addr), 32'h3FF);
                out_ready = 1'b1;
                step();
                chk("wrap_addr1", 32'(out_addr), 32'h000);
                chk("wrap_valid", 32'(out_valid), 32'd1);
                step();

                // asynchronous reset mid-stream
                out_ready = 1'b0;
                for (int i = 0; i < 3; i++)
                    push(3'd0, 7'h33, 5'(i), 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
                #1;
                rst_n = 1'b0;
                #1;
                chk("arst_valid", 32'(out_valid), 32'd0);
                chk("arst_level", 32'(level), 32'd0);
                chk("arst_addr", 32'(out_addr), 32'd0);
                step(); step();
                rst_n = 1'b1;
                chk("arst_ready", 32'(in_ready), 32'd1);
                out_ready = 1'b1;
                push(3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
                step(); step();
            end
            begin : cmp
                forever begin
                    @(negedge clk);
                    if (rst_n) begin
                        chk("m_out_valid", 32'(out_valid), 32'(mq.size() != 0));
                        chk("m_level", 32'(level), 32'(mq.size()));
                        chk("m_in_ready", 32'(in_ready), 32'(model_ready()));
                        chk("m_err", 32'(err), 32'(merr));
                        chk("m_out_addr", 32'(out_addr), 32'(maddr));
                        if (mq.size() != 0)
                            chk("m_out_instr", out_instr, mq[0]);
                    end
                end
            end
        join_any
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
